// File: rtl/arb_pkg.sv
// Shared definitions for the 4-way round-robin bus arbiter: FSM encoding,
// requester count, timeout sizing and the one-hot grant/mux-select constants.
package arb_pkg;

    localparam int NUM_REQ        = 4;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int CNT_W          = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // Same encoding as the select of the one-hot data mux.
    localparam logic [NUM_REQ-1:0] GNT_0 = 4'b0001;
    localparam logic [NUM_REQ-1:0] GNT_1 = 4'b0010;
    localparam logic [NUM_REQ-1:0] GNT_2 = 4'b0100;
    localparam logic [NUM_REQ-1:0] GNT_3 = 4'b1000;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [1:0] idx);
        logic [NUM_REQ-1:0] v;
        case (idx)
            2'd0:    v = GNT_0;
            2'd1:    v = GNT_1;
            2'd2:    v = GNT_2;
            default: v = GNT_3;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request bit starting at ptr,
// searching upward modulo 4.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic [1:0]         winner,
    output logic               any
);

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [1:0]           w_off;

    // Rotate so that bit 0 of w_rot is the requester at ptr.
    assign w_dbl = {req, req};
    assign w_rot = w_dbl[ptr +: NUM_REQ];

    always_comb begin
        w_off = 2'd0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = 2'(i);
            end
        end
    end

    assign winner = ptr + w_off;
    assign any    = |req;

endmodule

// File: rtl/bus_arbiter4.sv
// Round-robin arbiter granting one shared 32-bit port to 4 requesters, holding
// each grant until done or abandon. Optional forced release: define ARB_TIMEOUT_EN.
module bus_arbiter4
    import arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [1:0]         grant_id,
    output logic               timeout
);

    arb_state_t         r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [1:0]         r_grant_id;
    logic [1:0]         r_ptr;
    logic               r_timeout;

    logic [1:0] w_winner;
    logic       w_any;
    logic       w_abandon;
    logic       w_limit;
    logic       w_release;

    rr_pick4 u_pick (
        .req    (req),
        .ptr    (r_ptr),
        .winner (w_winner),
        .any    (w_any)
    );

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == ST_IDLE) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_limit = (r_state == ST_BUSY) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_limit = 1'b0;
`endif

    assign w_abandon = ~req[r_grant_id];
    assign w_release = done | w_abandon | w_limit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_grant_id <= 2'd0;
            r_ptr      <= 2'd0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state    <= ST_BUSY;
                        r_grant    <= onehot(w_winner);
                        r_grant_id <= w_winner;
                    end
                end
                ST_BUSY: begin
                    if (w_release) begin
                        r_state    <= ST_IDLE;
                        r_grant    <= '0;
                        r_grant_id <= 2'd0;
                        r_ptr      <= r_grant_id + 2'd1;
                        // A completing transfer wins over the hold limit.
                        r_timeout  <= w_limit & ~done;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign grant       = r_grant;
    assign grant_valid = |r_grant;
    assign grant_id    = r_grant_id;
    assign timeout     = r_timeout;

endmodule

// File: tb/tb_bus_arbiter4.sv
// Directed bench for bus_arbiter4: vector table plus hand-written multi-cycle
// sequences (rotation, async reset, hold limit).
module tb_bus_arbiter4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic       timeout;

    int checks = 0;
    int passes = 0;

    bus_arbiter4 dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] req;
        logic       done;
        logic [3:0] g;
        logic [1:0] id;
        logic       to;
    } vec_t;

    vec_t vecs[21];

    task automatic check_out(input string name, input logic [3:0] eg,
                             input logic [1:0] eid, input logic eto);
        logic ev;
        ev = |eg;
        checks++;
        if (grant === eg && grant_id === eid && grant_valid === ev && timeout === eto) begin
            passes++;
            $display("ok   %s: grant=%b id=%0d valid=%b timeout=%b", name, grant, grant_id,
                     grant_valid, timeout);
        end else begin
            $display("FAIL %s: got grant=%b id=%0d valid=%b timeout=%b, required grant=%b id=%0d valid=%b timeout=%b",
                     name, grant, grant_id, grant_valid, timeout, eg, eid, ev, eto);
        end
    endtask

    initial begin
        logic [3:0] exp_g;

        //           req      done  grant    id    to
        vecs[0]  = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0};
        vecs[1]  = '{4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0};
        vecs[2]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
        vecs[3]  = '{4'b1001, 1'b0, 4'b1000, 2'd3, 1'b0};
        vecs[4]  = '{4'b1001, 1'b1, 4'b0000, 2'd0, 1'b0};
        vecs[5]  = '{4'b1001, 1'b0, 4'b0001, 2'd0, 1'b0};
        vecs[6]  = '{4'b1001, 1'b1, 4'b0000, 2'd0, 1'b0};
        vecs[7]  = '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0};
        vecs[8]  = '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0};
        vecs[9]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
        vecs[10] = '{4'b0011, 1'b0, 4'b0001, 2'd0, 1'b0};
        vecs[11] = '{4'b0011, 1'b1, 4'b0000, 2'd0, 1'b0};
        vecs[12] = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0};
        vecs[13] = '{4'b1000, 1'b1, 4'b1000, 2'd3, 1'b0};
        vecs[14] = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0};
        vecs[15] = '{4'b0110, 1'b0, 4'b0010, 2'd1, 1'b0};
        vecs[16] = '{4'b0111, 1'b0, 4'b0010, 2'd1, 1'b0};
        vecs[17] = '{4'b0101, 1'b0, 4'b0000, 2'd0, 1'b0};
        vecs[18] = '{4'b0101, 1'b0, 4'b0100, 2'd2, 1'b0};
        vecs[19] = '{4'b0101, 1'b1, 4'b0000, 2'd0, 1'b0};
        vecs[20] = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};

        rst  = 1'b1;
        req  = 4'b0000;
        done = 1'b0;
        #3;
        check_out("reset_hold", 4'b0000, 2'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_out("reset_idle", 4'b0000, 2'd0, 1'b0);

        // Inputs applied at a falling edge, result checked one cycle later.
        for (int i = 0; i < 21; i++) begin
            req  = vecs[i].req;
            done = vecs[i].done;
            @(negedge clk);
            check_out($sformatf("vec%0d", i), vecs[i].g, vecs[i].id, vecs[i].to);
        end
        done = 1'b0;
        req  = 4'b0000;

        // Fairness rotation from ptr=0 with one idle turnaround cycle.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            @(negedge clk);
            check_out($sformatf("rot%0d_grant", k), exp_g, 2'(k % 4), 1'b0);
            @(negedge clk);
            @(negedge clk);
            done = 1'b1;
            @(negedge clk);
            done = 1'b0;
            check_out($sformatf("rot%0d_gap", k), 4'b0000, 2'd0, 1'b0);
        end
        req = 4'b0000;
        @(negedge clk);
        check_out("rot_end_idle", 4'b0000, 2'd0, 1'b0);

        // Async reset mid-transaction, ptr pointing away from 0 beforehand.
        req = 4'b0100;
        @(negedge clk);
        check_out("pre_rst_grant", 4'b0100, 2'd2, 1'b0);
        #2 rst = 1'b1;
        #1 check_out("async_rst", 4'b0000, 2'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1111;
        @(negedge clk);
        check_out("post_rst_grant", 4'b0001, 2'd0, 1'b0);
        done = 1'b1;
        req  = 4'b0000;
        @(negedge clk);
        done = 1'b0;
        check_out("post_rst_idle", 4'b0000, 2'd0, 1'b0);

`ifdef ARB_TIMEOUT_EN
        req = 4'b0001;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check_out($sformatf("to_hold%0d", k), 4'b0001, 2'd0, 1'b0);
        end
        req = 4'b0000;
        @(negedge clk);
        check_out("to_fire", 4'b0000, 2'd0, 1'b1);
        @(negedge clk);
        check_out("to_pulse_end", 4'b0000, 2'd0, 1'b0);

        req = 4'b0001;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check_out($sformatf("tod_hold%0d", k), 4'b0001, 2'd0, 1'b0);
        end
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        req  = 4'b0000;
        check_out("tod_no_timeout", 4'b0000, 2'd0, 1'b0);
        @(negedge clk);
        check_out("tod_idle", 4'b0000, 2'd0, 1'b0);
`else
        req = 4'b0001;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check_out($sformatf("hold%0d", k), 4'b0001, 2'd0, 1'b0);
        end
        req = 4'b0000;
        @(negedge clk);
        check_out("hold_abandon", 4'b0000, 2'd0, 1'b0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
